// File: rtl/rob_flush.sv
// Reorder buffer with in-order commit, CDB completion and mispredict flush to a surviving index.
// Optional same-cycle CDB-to-decode forwarding is enabled by defining ROB_CDB_BYPASS_EN.
module rob_flush #(
   parameter int                 SIZE       = 8,
   parameter int                 DATA_W     = 32,
   parameter int                 ITYPE_W    = 4,
   parameter logic [ITYPE_W-1:0] STORE_TYPE = ITYPE_W'(2),
   localparam int                PTR_W      = $clog2(SIZE)
) (
   input  logic               clk_in,
   input  logic               rst_n_in,
   input  logic [PTR_W-1:0]   decode_rob1_ix_in,
   input  logic [PTR_W-1:0]   decode_rob2_ix_in,
   output logic [DATA_W-1:0]  decode_value1_out,
   output logic [DATA_W-1:0]  decode_value2_out,
   output logic               decode_ready1_out,
   output logic               decode_ready2_out,
   input  logic               valid_in,
   input  logic [ITYPE_W-1:0] iType_in,
   input  logic [DATA_W-1:0]  value_in,
   input  logic [DATA_W-1:0]  dest_in,
   output logic [PTR_W-1:0]   inst_rob_ix_out,
   output logic               ready_out,
   input  logic               cdb_valid_in,
   input  logic [PTR_W-1:0]   cdb_rob_ix_in,
   input  logic [DATA_W-1:0]  cdb_value_in,
   input  logic [DATA_W-1:0]  cdb_dest_in,
   input  logic               flush_in,
   input  logic [PTR_W-1:0]   flush_rob_ix_in,
   output logic               commit_out,
   input  logic               commit_ack_in,
   output logic [PTR_W-1:0]   ix_out,
   output logic [ITYPE_W-1:0] iType_out,
   output logic [DATA_W-1:0]  value_out,
   output logic [DATA_W-1:0]  dest_out,
   output logic [PTR_W:0]     count_out
);

   logic [SIZE-1:0]    valid_q, done_q;
   logic [SIZE-1:0]    valid_nxt, done_nxt;
   logic [PTR_W-1:0]   head_q, tail_q;
   logic [PTR_W:0]     count_q;
   logic [ITYPE_W-1:0] itype_mem [SIZE];
   logic [DATA_W-1:0]  value_mem [SIZE];
   logic [DATA_W-1:0]  dest_mem  [SIZE];

   logic               issue, retire, flush_ok, cdb_hit;
   logic [PTR_W-1:0]   flush_rel;
   logic [PTR_W-1:0]   rel;
   logic [SIZE-1:0]    kill;
   logic [PTR_W:0]     flush_count;

   assign ready_out  = count_q < (PTR_W+1)'(SIZE);
   assign issue      = valid_in && ready_out && !flush_in;
   assign commit_out = valid_q[head_q] && done_q[head_q];
   assign retire     = commit_out && commit_ack_in;
   assign flush_ok   = flush_in && valid_q[flush_rob_ix_in];
   assign flush_rel  = flush_rob_ix_in - head_q;

   // Age is measured as distance from head, so wrap-around needs no special case.
   always_comb begin
      kill = '0;
      rel  = '0;
      for (int i = 0; i < SIZE; i++) begin
         rel = PTR_W'(i) - head_q;
         if (flush_ok && valid_q[i] && (rel > flush_rel))
            kill[i] = 1'b1;
      end
   end

   assign cdb_hit     = cdb_valid_in && valid_q[cdb_rob_ix_in] && !kill[cdb_rob_ix_in];
   assign flush_count = (PTR_W+1)'(flush_rel) + (PTR_W+1)'(1) - (PTR_W+1)'(retire);

   always_comb begin
      valid_nxt = valid_q & ~kill;
      done_nxt  = done_q;
      if (cdb_hit)
         done_nxt[cdb_rob_ix_in] = 1'b1;
      if (retire)
         valid_nxt[head_q] = 1'b0;
      if (issue) begin
         valid_nxt[tail_q] = 1'b1;
         done_nxt[tail_q]  = 1'b0;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
         done_q  <= '0;
      end else begin
         valid_q <= valid_nxt;
         done_q  <= done_nxt;
         if (retire)
            head_q <= head_q + PTR_W'(1);
         if (flush_ok) begin
            tail_q  <= flush_rob_ix_in + PTR_W'(1);
            count_q <= flush_count;
         end else begin
            if (issue)
               tail_q <= tail_q + PTR_W'(1);
            if (issue && !retire)
               count_q <= count_q + (PTR_W+1)'(1);
            else if (!issue && retire)
               count_q <= count_q - (PTR_W+1)'(1);
         end
      end
   end

   // Payload storage carries no reset; validity lives entirely in valid_q.
   always_ff @(posedge clk_in) begin
      if (issue) begin
         itype_mem[tail_q] <= iType_in;
         value_mem[tail_q] <= value_in;
         dest_mem[tail_q]  <= dest_in;
      end
      if (cdb_hit) begin
         value_mem[cdb_rob_ix_in] <= cdb_value_in;
         if (itype_mem[cdb_rob_ix_in] == STORE_TYPE)
            dest_mem[cdb_rob_ix_in] <= cdb_dest_in;
      end
   end

   assign inst_rob_ix_out = tail_q;
   assign ix_out          = head_q;
   assign iType_out       = itype_mem[head_q];
   assign value_out       = value_mem[head_q];
   assign dest_out        = dest_mem[head_q];
   assign count_out       = count_q;

`ifdef ROB_CDB_BYPASS_EN
   logic byp1, byp2;
   assign byp1 = cdb_valid_in && (decode_rob1_ix_in == cdb_rob_ix_in) && valid_q[cdb_rob_ix_in];
   assign byp2 = cdb_valid_in && (decode_rob2_ix_in == cdb_rob_ix_in) && valid_q[cdb_rob_ix_in];
   assign decode_value1_out = byp1 ? cdb_value_in : value_mem[decode_rob1_ix_in];
   assign decode_value2_out = byp2 ? cdb_value_in : value_mem[decode_rob2_ix_in];
   assign decode_ready1_out = byp1 || (valid_q[decode_rob1_ix_in] && done_q[decode_rob1_ix_in]);
   assign decode_ready2_out = byp2 || (valid_q[decode_rob2_ix_in] && done_q[decode_rob2_ix_in]);
`else
   assign decode_value1_out = value_mem[decode_rob1_ix_in];
   assign decode_value2_out = value_mem[decode_rob2_ix_in];
   assign decode_ready1_out = valid_q[decode_rob1_ix_in] && done_q[decode_rob1_ix_in];
   assign decode_ready2_out = valid_q[decode_rob2_ix_in] && done_q[decode_rob2_ix_in];
`endif

endmodule
